mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Multi-master front end that sits directly upstream of the DDR memory controller in the `clk_sys` domain. It round-robin arbitrates up to `NUM_PORTS` requesters onto the controller's single command, write-data and read-data channels. Write bursts are steered from the granted port. Read data is returned to the issuing port in order, using a small tag FIFO.

## Interface
- `NUM_PORTS`, 4: requester count, 2..8.
- `ADDR_W`, 32: command address width.
- `DATA_W`, 128: data width; `STRB_W` = `DATA_W/8`.
- `LEN_W`, 8: burst length field; value = beats − 1.
- `TAG_DEPTH`, 8: outstanding read bursts, power of two.

Ports:
- `clk_sys` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `p_cmd_valid` in N, `p_cmd_ready` out N: per-port command handshake.
- `p_cmd_addr` in N·ADDR_W, `p_cmd_write` in N, `p_cmd_burst_len` in N·LEN_W: packed per-port command fields, port 0 in the LSBs.
- `p_wr_data` in N·DATA_W, `p_wr_strobe` in N·STRB_W, `p_wr_valid` in N, `p_wr_ready` out N: per-port write data.
- `p_rd_data` out DATA_W (broadcast), `p_rd_valid` out N, `p_rd_ready` in N: per-port read return.
- `m_cmd_valid` out 1, `m_cmd_ready` in 1, `m_cmd_addr` out ADDR_W, `m_cmd_write` out 1, `m_cmd_burst_len` out LEN_W: command channel to the controller.
- `m_wr_data` out DATA_W, `m_wr_strobe` out STRB_W, `m_wr_valid` out 1, `m_wr_ready` in 1: write channel to the controller.
- `m_rd_data` in DATA_W, `m_rd_valid` in 1, `m_rd_ready` out 1: read channel from the controller.
- `busy` out 1: state ≠ IDLE or tag FIFO non-empty.
- `err_orphan_rd` out 1: sticky; set by read data that arrives while the tag FIFO is empty.

## Operation
- Command FSM states: IDLE, CMD, WDATA.
- IDLE:
  - Combinational round-robin search starts at `rr_ptr+1` and wraps.
  - Eligible port: `p_cmd_valid` high, and not (read request AND tag FIFO full).
  - Winner gets `p_cmd_ready` high in the same cycle.
  - Its addr/write/len and index are latched, `rr_ptr` ← winner, next state CMD.
- CMD:
  - `m_cmd_*` driven from the latched registers, `m_cmd_valid`=1.
  - On `m_cmd_ready`, a read pushes {port, len} into the tag FIFO and goes to IDLE.
  - On `m_cmd_ready`, a write loads `wbeats` ← len and goes to WDATA.
- WDATA:
  - Combinational pass-through from the granted port only: `m_wr_valid`/data/strobe ← granted port, `p_wr_ready[g]` ← `m_wr_ready`.
  - Each handshake decrements `wbeats`.
  - The handshake at `wbeats`=0 returns the FSM to IDLE.
- Read return runs independently of the FSM:
  - With the FIFO non-empty, head port h: `p_rd_valid[h]` ← `m_rd_valid`, `m_rd_ready` ← `p_rd_ready[h]`. All other `p_rd_valid` are 0.
  - `rbeats` counts up per handshake. The handshake where `rbeats`==head.len pops the FIFO and clears `rbeats`.
  - FIFO empty: `m_rd_ready`=0. `m_rd_valid`=1 in that condition sets `err_orphan_rd`.
- A push and a pop in the same cycle are both honoured and the count is unchanged.
- The full check uses the registered count; a pop in the same cycle does not unblock a read.

## Timing
- Reset values:
  - FSM IDLE, `rr_ptr`=NUM_PORTS−1 (port 0 wins first).
  - FIFO empty; `rbeats`, `wbeats` = 0.
  - All ready/valid outputs 0, `m_cmd_*` registers 0, `busy`=0, `err_orphan_rd`=0.
- Reset asserted mid-burst aborts immediately; no recovery handshake.
- Grant latency:
  - Request accepted in the cycle it is seen in IDLE.
  - `m_cmd_valid` rises the next cycle.
  - Peak rate is one command per 2 cycles; writes add at least len+1 cycles.
- `m_cmd_*` stay stable while `m_cmd_valid` is high and `m_cmd_ready` is low.
- Write and read data paths add zero latency (combinational), with no buffering.
- `LEN_W`=8 allows up to 256 beats; counters are `LEN_W` bits wide and must not wrap within a burst.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_e` {IDLE, CMD, WDATA}.
  - `PORT_IDX_W` = $clog2(NUM_PORTS).
  - `rd_tag_t` {port index, len}.
- Sub-module `mem_arb_tag_fifo`: synchronous FIFO of `rd_tag_t`, depth `TAG_DEPTH`, with full/empty/count outputs and asynchronous active-high reset.
- Top level contains the arbiter, the FSM, the write steering and the read steering.

## Test plan
- **Reset priority:** all ports request reads after reset → grants in order 0,1,2,3,0; `m_cmd_valid` exactly one cycle after each `p_cmd_ready`.
- **Write steering:** port 2 writes len=3 while `m_wr_ready` toggles 1,0,1,0… → exactly 4 beats forwarded with matching data/strobe; `p_wr_ready` stays 0 on ports 0,1,3; FSM in IDLE after the 4th beat.
- **In-order read return:** ports 1 and 3 issue reads len=1 and len=0 → `m_rd` beats route to port 1 twice, then to port 3 once; FIFO empty and `busy`=0 afterward.
- **Tag FIFO full:** issue 8 outstanding reads with `m_rd_valid`=0 → a 9th read is not granted while a concurrent write from another port is granted; after one burst drains, the read is granted.
- **Back-pressure and orphans:** `p_rd_ready[h]`=0 holds `m_rd_ready`=0 with data unchanged; `m_rd_valid`=1 with FIFO empty sets `err_orphan_rd`, which stays 1 until `rst`.
- **Reset mid-burst:** assert `rst` during WDATA beat 2 of len=7 → all outputs return to reset values; the next request is granted normally starting from port 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types for the DDR front-end request arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2
  } arb_state_e;

  // Tag fields are sized for the largest supported configuration.
  localparam int NUM_PORTS_MAX = 8;
  localparam int PORT_IDX_W    = $clog2(NUM_PORTS_MAX);
  localparam int TAG_LEN_W     = 16;

  typedef struct packed {
    logic [PORT_IDX_W-1:0] port;
    logic [TAG_LEN_W-1:0]  len;
  } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_tag_fifo.sv
// ============================================================================
// Module   : mem_arb_tag_fifo
// Brief    : Synchronous FIFO of outstanding read tags {port, len}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  rd_tag_t                  push_data,
  input  logic                     pop,
  output rd_tag_t                  pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  rd_tag_t        r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
// ============================================================================
// Module   : mem_req_arbiter
// Brief    : Round-robin multi-port front end for the DDR controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 128,
  parameter  int LEN_W     = 8,
  parameter  int TAG_DEPTH = 8,
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                        clk_sys,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        p_cmd_valid,
  output logic [NUM_PORTS-1:0]        p_cmd_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_cmd_addr,
  input  logic [NUM_PORTS-1:0]        p_cmd_write,
  input  logic [NUM_PORTS*LEN_W-1:0]  p_cmd_burst_len,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wr_data,
  input  logic [NUM_PORTS*STRB_W-1:0] p_wr_strobe,
  input  logic [NUM_PORTS-1:0]        p_wr_valid,
  output logic [NUM_PORTS-1:0]        p_wr_ready,
  output logic [DATA_W-1:0]           p_rd_data,
  output logic [NUM_PORTS-1:0]        p_rd_valid,
  input  logic [NUM_PORTS-1:0]        p_rd_ready,
  output logic                        m_cmd_valid,
  input  logic                        m_cmd_ready,
  output logic [ADDR_W-1:0]           m_cmd_addr,
  output logic                        m_cmd_write,
  output logic [LEN_W-1:0]            m_cmd_burst_len,
  output logic [DATA_W-1:0]           m_wr_data,
  output logic [STRB_W-1:0]           m_wr_strobe,
  output logic                        m_wr_valid,
  input  logic                        m_wr_ready,
  input  logic [DATA_W-1:0]           m_rd_data,
  input  logic                        m_rd_valid,
  output logic                        m_rd_ready,
  output logic                        busy,
  output logic                        err_orphan_rd
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e                  r_state;
  arb_state_e                  w_state_nxt;
  logic [IDX_W-1:0]            r_rr_ptr;
  logic [IDX_W-1:0]            r_gnt;
  logic [ADDR_W-1:0]           r_cmd_addr;
  logic                        r_cmd_write;
  logic [LEN_W-1:0]            r_cmd_len;
  logic [LEN_W-1:0]            r_wbeats;
  logic [LEN_W-1:0]            r_rbeats;
  logic                        r_err;

  logic [ADDR_W-1:0]           w_addr  [NUM_PORTS];
  logic [LEN_W-1:0]            w_len   [NUM_PORTS];
  logic [DATA_W-1:0]           w_wdata [NUM_PORTS];
  logic [STRB_W-1:0]           w_wstrb [NUM_PORTS];
  logic [NUM_PORTS-1:0]        w_elig;
  logic [NUM_PORTS-1:0]        w_rd_sel;
  logic                        w_found;
  logic [IDX_W-1:0]            w_win;
  logic                        w_grant;
  logic                        w_push;
  logic                        w_wr_hs;
  logic                        w_rd_hs;
  logic                        w_rd_last;
  rd_tag_t                     w_push_tag;
  rd_tag_t                     w_head;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [$clog2(TAG_DEPTH):0]  w_fifo_count;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign w_addr[i]     = p_cmd_addr[i*ADDR_W +: ADDR_W];
    assign w_len[i]      = p_cmd_burst_len[i*LEN_W +: LEN_W];
    assign w_wdata[i]    = p_wr_data[i*DATA_W +: DATA_W];
    assign w_wstrb[i]    = p_wr_strobe[i*STRB_W +: STRB_W];
    assign w_elig[i]     = p_cmd_valid[i] && (p_cmd_write[i] || !w_fifo_full);
    assign w_rd_sel[i]   = !w_fifo_empty && (w_head.port == PORT_IDX_W'(i));
    assign p_rd_valid[i] = w_rd_sel[i] && m_rd_valid;
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
      if (!w_found && w_elig[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    p_cmd_ready = '0;
    p_wr_ready  = '0;
    m_cmd_valid = 1'b0;
    m_wr_valid  = 1'b0;
    w_grant     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          p_cmd_ready[w_win] = 1'b1;
          w_grant            = 1'b1;
          w_state_nxt        = CMD;
        end
      end
      CMD: begin
        m_cmd_valid = 1'b1;
        if (m_cmd_ready) begin
          if (r_cmd_write) begin
            w_state_nxt = WDATA;
          end else begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      WDATA: begin
        m_wr_valid        = p_wr_valid[r_gnt];
        p_wr_ready[r_gnt] = m_wr_ready;
        if (p_wr_valid[r_gnt] && m_wr_ready && (r_wbeats == '0))
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_wr_hs   = m_wr_valid && m_wr_ready;
  assign w_rd_hs   = m_rd_valid && m_rd_ready;
  assign w_rd_last = (TAG_LEN_W'(r_rbeats) == w_head.len);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= IDX_W'(NUM_PORTS - 1);
      r_gnt       <= '0;
      r_cmd_addr  <= '0;
      r_cmd_write <= 1'b0;
      r_cmd_len   <= '0;
      r_wbeats    <= '0;
      r_rbeats    <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr    <= w_win;
        r_gnt       <= w_win;
        r_cmd_addr  <= w_addr[w_win];
        r_cmd_write <= p_cmd_write[w_win];
        r_cmd_len   <= w_len[w_win];
      end
      if (m_cmd_valid && m_cmd_ready && r_cmd_write)
        r_wbeats <= r_cmd_len;
      else if (w_wr_hs && (r_wbeats != '0))
        r_wbeats <= r_wbeats - 1'b1;
      if (w_rd_hs)
        r_rbeats <= w_rd_last ? '0 : r_rbeats + 1'b1;
      if (m_rd_valid && w_fifo_empty)
        r_err <= 1'b1;
    end
  end

  assign w_push_tag.port = PORT_IDX_W'(r_gnt);
  assign w_push_tag.len  = TAG_LEN_W'(r_cmd_len);

  mem_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk_sys),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_tag),
    .pop       (w_rd_hs && w_rd_last),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign m_cmd_addr      = r_cmd_addr;
  assign m_cmd_write     = r_cmd_write;
  assign m_cmd_burst_len = r_cmd_len;
  assign m_wr_data       = w_wdata[r_gnt];
  assign m_wr_strobe     = w_wstrb[r_gnt];
  assign p_rd_data       = m_rd_data;
  assign m_rd_ready      = |(w_rd_sel & p_rd_ready);
  assign busy            = (r_state != IDLE) || (w_fifo_count != '0);
  assign err_orphan_rd   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
// ============================================================================
// Module   : tb_mem_req_arbiter
// Brief    : Directed, table-driven checks of the DDR front-end arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int LW = 8;
  localparam int SW = DW / 8;

  logic              clk_sys;
  logic              rst;
  logic [N-1:0]      p_cmd_valid;
  logic [N-1:0]      p_cmd_ready;
  logic [N*AW-1:0]   p_cmd_addr;
  logic [N-1:0]      p_cmd_write;
  logic [N*LW-1:0]   p_cmd_burst_len;
  logic [N*DW-1:0]   p_wr_data;
  logic [N*SW-1:0]   p_wr_strobe;
  logic [N-1:0]      p_wr_valid;
  logic [N-1:0]      p_wr_ready;
  logic [DW-1:0]     p_rd_data;
  logic [N-1:0]      p_rd_valid;
  logic [N-1:0]      p_rd_ready;
  logic              m_cmd_valid;
  logic              m_cmd_ready;
  logic [AW-1:0]     m_cmd_addr;
  logic              m_cmd_write;
  logic [LW-1:0]     m_cmd_burst_len;
  logic [DW-1:0]     m_wr_data;
  logic [SW-1:0]     m_wr_strobe;
  logic              m_wr_valid;
  logic              m_wr_ready;
  logic [DW-1:0]     m_rd_data;
  logic              m_rd_valid;
  logic              m_rd_ready;
  logic              busy;
  logic              err_orphan_rd;

  mem_req_arbiter #(
    .NUM_PORTS (N), .ADDR_W (AW), .DATA_W (DW), .LEN_W (LW), .TAG_DEPTH (8)
  ) dut (
    .clk_sys         (clk_sys),
    .rst             (rst),
    .p_cmd_valid     (p_cmd_valid),
    .p_cmd_ready     (p_cmd_ready),
    .p_cmd_addr      (p_cmd_addr),
    .p_cmd_write     (p_cmd_write),
    .p_cmd_burst_len (p_cmd_burst_len),
    .p_wr_data       (p_wr_data),
    .p_wr_strobe     (p_wr_strobe),
    .p_wr_valid      (p_wr_valid),
    .p_wr_ready      (p_wr_ready),
    .p_rd_data       (p_rd_data),
    .p_rd_valid      (p_rd_valid),
    .p_rd_ready      (p_rd_ready),
    .m_cmd_valid     (m_cmd_valid),
    .m_cmd_ready     (m_cmd_ready),
    .m_cmd_addr      (m_cmd_addr),
    .m_cmd_write     (m_cmd_write),
    .m_cmd_burst_len (m_cmd_burst_len),
    .m_wr_data       (m_wr_data),
    .m_wr_strobe     (m_wr_strobe),
    .m_wr_valid      (m_wr_valid),
    .m_wr_ready      (m_wr_ready),
    .m_rd_data       (m_rd_data),
    .m_rd_valid      (m_rd_valid),
    .m_rd_ready      (m_rd_ready),
    .busy            (busy),
    .err_orphan_rd   (err_orphan_rd)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  cmd_valid;
    logic [3:0]  exp_ready;
    logic        exp_mvalid;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t       vt [10];
  logic [3:0] drain_exp [5];
  logic [3:0] rd_exp [3];
  logic [31:0] wd;
  int          beats;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+2.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    p_cmd_valid     = '0;
    p_cmd_write     = '0;
    p_cmd_addr      = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    p_cmd_burst_len = '0;
    p_wr_data       = {4{128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0}};
    p_wr_strobe     = {4{16'hFFFF}};
    p_wr_valid      = '0;
    p_rd_ready      = '0;
    m_cmd_ready     = 1'b0;
    m_wr_ready      = 1'b0;
    m_rd_data       = '0;
    m_rd_valid      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk_sys);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'hF, 4'h1, 1'b0, 32'h0};
    vt[1] = '{4'hF, 4'h0, 1'b1, 32'h1000};
    vt[2] = '{4'hF, 4'h2, 1'b0, 32'h0};
    vt[3] = '{4'hF, 4'h0, 1'b1, 32'h2000};
    vt[4] = '{4'hF, 4'h4, 1'b0, 32'h0};
    vt[5] = '{4'hF, 4'h0, 1'b1, 32'h3000};
    vt[6] = '{4'hF, 4'h8, 1'b0, 32'h0};
    vt[7] = '{4'hF, 4'h0, 1'b1, 32'h4000};
    vt[8] = '{4'hF, 4'h1, 1'b0, 32'h0};
    vt[9] = '{4'hF, 4'h0, 1'b1, 32'h1000};
    drain_exp[0] = 4'h1; drain_exp[1] = 4'h2; drain_exp[2] = 4'h4;
    drain_exp[3] = 4'h8; drain_exp[4] = 4'h1;
    rd_exp[0] = 4'h2; rd_exp[1] = 4'h2; rd_exp[2] = 4'h8;

    // ---------------- reset state
    do_reset();
    settle();
    chk("rst_cmd_ready", p_cmd_ready, 0);
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_m_cmd_addr", m_cmd_addr, 0);
    chk("rst_m_cmd_len", m_cmd_burst_len, 0);
    chk("rst_m_wr_valid", m_wr_valid, 0);
    chk("rst_m_rd_ready", m_rd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_orphan_rd, 0);

    // ---------------- reset priority, all ports reading
    m_cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p_cmd_valid = vt[i].cmd_valid;
      settle();
      chk($sformatf("prio_ready[%0d]", i), p_cmd_ready, vt[i].exp_ready);
      chk($sformatf("prio_mvalid[%0d]", i), m_cmd_valid, vt[i].exp_mvalid);
      if (vt[i].exp_mvalid) begin
        chk($sformatf("prio_addr[%0d]", i), m_cmd_addr, vt[i].exp_addr);
        chk($sformatf("prio_write[%0d]", i), m_cmd_write, 0);
      end
      tick();
    end
    p_cmd_valid = '0;
    p_rd_ready  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = 128'h100 + 128'(i);
      settle();
      chk($sformatf("drain_pvalid[%0d]", i), p_rd_valid, drain_exp[i]);
      chk($sformatf("drain_mready[%0d]", i), m_rd_ready, 1);
      tick();
    end
    m_rd_valid = 1'b0;
    settle();
    chk("drain_busy", busy, 0);

    // ---------------- write steering, port 2, len 3
    do_reset();
    p_cmd_valid = 4'b0100;
    p_cmd_write = 4'b0100;
    p_cmd_burst_len = {8'd0, 8'd3, 8'd0, 8'd0};
    settle();
    chk("wr_grant", p_cmd_ready, 4'b0100);
    tick();
    p_cmd_valid = '0;
    m_cmd_ready = 1'b1;
    settle();
    chk("wr_cmd_valid", m_cmd_valid, 1);
    chk("wr_cmd_write", m_cmd_write, 1);
    chk("wr_cmd_len", m_cmd_burst_len, 3);
    chk("wr_cmd_addr", m_cmd_addr, 32'h3000);
    tick();
    m_cmd_ready = 1'b0;
    p_wr_valid  = 4'hF;
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      m_wr_ready = (c % 2 == 0);
      wd = 32'hD0 + 32'(beats);
      p_wr_data[2*DW +: DW]   = {4{wd}};
      p_wr_strobe[2*SW +: SW] = 16'h0001 << beats;
      settle();
      chk("wr_ready_others", p_wr_ready & 4'b1011, 0);
      chk("wr_ready_port2", p_wr_ready[2], m_wr_ready);
      if (m_wr_valid && m_wr_ready) begin
        chk($sformatf("wr_data[%0d]", beats), m_wr_data, {4{wd}});
        chk($sformatf("wr_strb[%0d]", beats), m_wr_strobe, 16'h0001 << beats);
        beats++;
      end
      tick();
    end
    chk("wr_beat_count", beats, 4);
    m_wr_ready = 1'b1;
    settle();
    chk("wr_after_valid", m_wr_valid, 0);
    chk("wr_after_ready", p_wr_ready, 0);
    chk("wr_after_busy", busy, 0);

    // ---------------- in-order read return, port 1 len 1 then port 3 len 0
    do_reset();
    m_cmd_ready = 1'b1;
    p_cmd_burst_len = {8'd0, 8'd0, 8'd1, 8'd0};
    p_cmd_valid = 4'b1010;
    settle();
    chk("rd_grant1", p_cmd_ready, 4'b0010);
    tick();
    p_cmd_valid = 4'b1000;
    settle();
    chk("rd_cmd1_addr", m_cmd_addr, 32'h2000);
    chk("rd_cmd1_len", m_cmd_burst_len, 1);
    tick();
    settle();
    chk("rd_grant3", p_cmd_ready, 4'b1000);
    tick();
    p_cmd_valid = '0;
    settle();
    chk("rd_cmd3_addr", m_cmd_addr, 32'h4000);
    chk("rd_cmd3_valid", m_cmd_valid, 1);
    tick();
    p_rd_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = 128'hCAFE0 + 128'(i);
      settle();
      chk($sformatf("rd_route[%0d]", i), p_rd_valid, rd_exp[i]);
      chk($sformatf("rd_data[%0d]", i), p_rd_data, 128'hCAFE0 + 128'(i));
      tick();
    end
    m_rd_valid = 1'b0;
    settle();
    chk("rd_busy_after", busy, 0);
    chk("rd_err_after", err_orphan_rd, 0);

    // ---------------- tag FIFO full
    do_reset();
    m_cmd_ready = 1'b1;
    p_cmd_valid = 4'b0001;
    repeat (16) tick();
    p_cmd_valid = 4'b0010;
    settle();
    chk("full_read_blocked", p_cmd_ready, 0);
    chk("full_busy", busy, 1);
    tick();
    p_cmd_valid = 4'b0110;
    p_cmd_write = 4'b0100;
    settle();
    chk("full_write_granted", p_cmd_ready, 4'b0100);
    tick();
    settle();
    chk("full_wcmd_write", m_cmd_write, 1);
    tick();
    p_cmd_valid = 4'b0010;
    p_wr_valid  = 4'b0100;
    m_wr_ready  = 1'b1;
    settle();
    chk("full_wbeat", m_wr_valid, 1);
    tick();
    p_wr_valid = '0;
    settle();
    chk("full_still_blocked", p_cmd_ready, 0);
    tick();
    m_rd_valid = 1'b1;
    p_rd_ready = 4'hF;
    settle();
    chk("full_pop_route", p_rd_valid, 4'b0001);
    chk("full_pop_same_cycle", p_cmd_ready, 0);
    tick();
    m_rd_valid = 1'b0;
    settle();
    chk("full_read_unblocked", p_cmd_ready, 4'b0010);
    tick();
    p_cmd_valid = '0;
    settle();
    chk("full_read_addr", m_cmd_addr, 32'h2000);

    // ---------------- back-pressure and orphan data
    do_reset();
    m_rd_valid = 1'b1;
    m_rd_data  = 128'hAA;
    settle();
    chk("orph_mready", m_rd_ready, 0);
    chk("orph_pvalid", p_rd_valid, 0);
    tick();
    m_rd_valid = 1'b0;
    settle();
    chk("orph_err_set", err_orphan_rd, 1);
    m_cmd_ready = 1'b1;
    p_cmd_valid = 4'b0001;
    tick();
    p_cmd_valid = '0;
    settle();
    chk("bp_cmd_valid", m_cmd_valid, 1);
    tick();
    m_rd_valid = 1'b1;
    m_rd_data  = 128'hBEEF;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("bp_mready[%0d]", i), m_rd_ready, 0);
      chk($sformatf("bp_pvalid[%0d]", i), p_rd_valid, 4'b0001);
      chk($sformatf("bp_data[%0d]", i), p_rd_data, 128'hBEEF);
      tick();
    end
    p_rd_ready = 4'b0001;
    settle();
    chk("bp_release", m_rd_ready, 1);
    tick();
    m_rd_valid = 1'b0;
    p_rd_ready = '0;
    settle();
    chk("bp_busy_after", busy, 0);
    chk("orph_err_sticky", err_orphan_rd, 1);
    rst = 1'b1;
    #1;
    chk("orph_err_cleared", err_orphan_rd, 0);
    tick();
    rst = 1'b0;

    // ---------------- reset in the middle of a write burst
    do_reset();
    m_cmd_ready = 1'b1;
    p_cmd_valid = 4'b0010;
    p_cmd_write = 4'b0010;
    p_cmd_burst_len = {8'd0, 8'd0, 8'd7, 8'd0};
    settle();
    chk("mid_grant", p_cmd_ready, 4'b0010);
    tick();
    p_cmd_valid = '0;
    tick();
    p_wr_valid = 4'b0010;
    m_wr_ready = 1'b1;
    tick();
    tick();
    settle();
    chk("mid_beat2_valid", m_wr_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_wr_valid", m_wr_valid, 0);
    chk("mid_wr_ready", p_wr_ready, 0);
    chk("mid_cmd_valid", m_cmd_valid, 0);
    chk("mid_cmd_addr", m_cmd_addr, 0);
    chk("mid_busy", busy, 0);
    tick();
    rst = 1'b0;
    clear_inputs();
    m_cmd_ready = 1'b1;
    p_cmd_valid = 4'hF;
    settle();
    chk("mid_regrant", p_cmd_ready, 4'b0001);
    tick();
    p_cmd_valid = '0;
    settle();
    chk("mid_regrant_addr", m_cmd_addr, 32'h1000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
